// File: rtl/exc_commit_ctrl_pkg.sv
// exc_commit_ctrl_pkg: shared constants for the exception/ertn commit controller.
//   - Ecode / EsubCode values for each trap source.
//   - Bit positions of the trap flags inside wb_exc.
//   - Controller state encoding.
package exc_commit_ctrl_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  localparam logic [8:0] ESUBCODE_INT  = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_INE  = 9'h000;
  localparam logic [8:0] ESUBCODE_BRK  = 9'h000;
  localparam logic [8:0] ESUBCODE_SYS  = 9'h000;
  localparam logic [8:0] ESUBCODE_ALE  = 9'h000;

  localparam int unsigned EXC_ADEF = 4;
  localparam int unsigned EXC_INE  = 3;
  localparam int unsigned EXC_BRK  = 2;
  localparam int unsigned EXC_SYS  = 1;
  localparam int unsigned EXC_ALE  = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } state_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// exc_commit_ctrl_if: commit bus from the controller to the CSR file plus the
// redirect handshake to instruction fetch.
//   master: the controller (drives csr_* pulses and redirect_valid/redirect_pc).
//   slave : CSR file / IF side (drives redirect_ready).
// With CSR_BADV_EN defined the bus also carries csr_badv_we / csr_badv.
interface exc_commit_ctrl_if;
  logic        csr_wb_ex;
  logic        csr_ertn_flush;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_pc;
`ifdef CSR_BADV_EN
  logic        csr_badv_we;
  logic [31:0] csr_badv;
`endif
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output csr_wb_ex, csr_ertn_flush, csr_ecode, csr_esubcode, csr_pc,
`ifdef CSR_BADV_EN
    output csr_badv_we, csr_badv,
`endif
    output redirect_valid, redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  csr_wb_ex, csr_ertn_flush, csr_ecode, csr_esubcode, csr_pc,
`ifdef CSR_BADV_EN
    input  csr_badv_we, csr_badv,
`endif
    input  redirect_valid, redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/exc_commit_ctrl_prio.sv
// exc_prio_enc: combinational priority encoder for the WB trap sources.
//   has_int  in  pending interrupt (highest priority)
//   wb_exc   in  {ADEF, INE, BRK, SYS, ALE}
//   any      out some trap source is set
//   ecode    out Ecode of the winning source (0 when none)
//   esubcode out EsubCode of the winning source (0 when none)
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic       has_int,
  input  logic [4:0] wb_exc,
  output logic       any,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  always_comb begin
    any      = has_int | (|wb_exc);
    ecode    = '0;
    esubcode = '0;
    if (has_int) begin
      ecode    = ECODE_INT;
      esubcode = ESUBCODE_INT;
    end else if (wb_exc[EXC_ADEF]) begin
      ecode    = ECODE_ADEF;
      esubcode = ESUBCODE_ADEF;
    end else if (wb_exc[EXC_INE]) begin
      ecode    = ECODE_INE;
      esubcode = ESUBCODE_INE;
    end else if (wb_exc[EXC_BRK]) begin
      ecode    = ECODE_BRK;
      esubcode = ESUBCODE_BRK;
    end else if (wb_exc[EXC_SYS]) begin
      ecode    = ECODE_SYS;
      esubcode = ESUBCODE_SYS;
    end else if (wb_exc[EXC_ALE]) begin
      ecode    = ECODE_ALE;
      esubcode = ESUBCODE_ALE;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: sequences exception / interrupt / ertn commit between WB,
// the CSR file and instruction fetch.
//   IDLE -> COMMIT (one-cycle csr pulse) -> REDIRECT (handshake redirect_pc)
//   -> DRAIN (FLUSH_CYCLES extra flush cycles) -> IDLE. WB stalls meanwhile.
// Ports:
//   clk, resetn (async, active-low)
//   wb_valid, wb_pc, wb_exc, wb_ertn, has_int   WB instruction / interrupt
//   ex_entry, ertn_entry                        redirect targets
//   wb_ready, wb_retire                         WB control
//   flush, busy                                 pipeline kill / FSM status
//   cbus (exc_commit_ctrl_if.master)            CSR commit bus + IF redirect
// Optional build macro CSR_BADV_EN adds wb_vaddr and csr_badv_we/csr_badv.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wb_valid,
  input  logic [31:0]         wb_pc,
  input  logic [4:0]          wb_exc,
  input  logic                wb_ertn,
  input  logic                has_int,
  input  logic [31:0]         ex_entry,
  input  logic [31:0]         ertn_entry,
`ifdef CSR_BADV_EN
  input  logic [31:0]         wb_vaddr,
`endif
  output logic                wb_ready,
  output logic                wb_retire,
  output logic                flush,
  output logic                busy,
  exc_commit_ctrl_if.master   cbus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             kind_trap;

  logic             enc_any;
  logic [5:0]       enc_ecode;
  logic [8:0]       enc_esubcode;
  logic             trap;
  logic             ret;

  exc_prio_enc u_prio (
    .has_int  (has_int),
    .wb_exc   (wb_exc),
    .any      (enc_any),
    .ecode    (enc_ecode),
    .esubcode (enc_esubcode)
  );

  always_comb begin
    trap      = wb_valid & enc_any;
    ret       = wb_valid & wb_ertn & ~trap;
    wb_ready  = (state == IDLE);
    busy      = (state != IDLE);
    flush     = (state != IDLE);
    wb_retire = (state == IDLE) & wb_valid & ~trap & ~ret;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                <= IDLE;
      cnt                  <= '0;
      kind_trap            <= 1'b0;
      cbus.csr_wb_ex       <= 1'b0;
      cbus.csr_ertn_flush  <= 1'b0;
      cbus.csr_ecode       <= '0;
      cbus.csr_esubcode    <= '0;
      cbus.csr_pc          <= '0;
`ifdef CSR_BADV_EN
      cbus.csr_badv_we     <= 1'b0;
      cbus.csr_badv        <= '0;
`endif
      cbus.redirect_valid  <= 1'b0;
      cbus.redirect_pc     <= '0;
    end else begin
      // csr_* are single-cycle pulses: cleared every cycle unless entering COMMIT.
      cbus.csr_wb_ex       <= 1'b0;
      cbus.csr_ertn_flush  <= 1'b0;
      cbus.csr_ecode       <= '0;
      cbus.csr_esubcode    <= '0;
      cbus.csr_pc          <= '0;
`ifdef CSR_BADV_EN
      cbus.csr_badv_we     <= 1'b0;
      cbus.csr_badv        <= '0;
`endif
      case (state)
        IDLE: begin
          if (trap || ret) begin
            state               <= COMMIT;
            kind_trap           <= trap;
            cbus.csr_wb_ex      <= trap;
            cbus.csr_ertn_flush <= ret;
            if (trap) begin
              cbus.csr_ecode    <= enc_ecode;
              cbus.csr_esubcode <= enc_esubcode;
              cbus.csr_pc       <= wb_pc;
`ifdef CSR_BADV_EN
              if (enc_ecode == ECODE_ADEF) begin
                cbus.csr_badv_we <= 1'b1;
                cbus.csr_badv    <= wb_pc;
              end else if (enc_ecode == ECODE_ALE) begin
                cbus.csr_badv_we <= 1'b1;
                cbus.csr_badv    <= wb_vaddr;
              end
`endif
            end
          end
        end
        COMMIT: begin
          state               <= REDIRECT;
          cbus.redirect_valid <= 1'b1;
          cbus.redirect_pc    <= kind_trap ? ex_entry : ertn_entry;
        end
        REDIRECT: begin
          if (cbus.redirect_ready) begin
            cbus.redirect_valid <= 1'b0;
            cbus.redirect_pc    <= '0;
            if (FLUSH_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state <= DRAIN;
              cnt   <= CNT_W'(FLUSH_CYCLES);
            end
          end
        end
        DRAIN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
